// File: rtl/sdram_int_pkg.sv
// Shared types, widths and helpers for the internal SDRAM responder.
package sdram_int_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t RD_WAIT  = 2'd1;
  localparam state_t RD_BURST = 2'd2;
  localparam state_t REFRESH  = 2'd3;

  localparam int unsigned HW_W      = 16;
  localparam int unsigned LAT_W     = 3;
  localparam int unsigned REF_CNT_W = 16;
  localparam int unsigned REF_CYC_W = 4;

  // Number of bits needed to index 'value' items (ceil(log2)).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/int_mem_ram.sv
// Single-port synchronous RAM with two byte lanes; contents are not reset.
module int_mem_ram
  import sdram_int_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [1:0]      be,
  input  logic [HW_W-1:0] wdata,
  input  logic            re,
  output logic [HW_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [HW_W-1:0] mem_q [DEPTH];
  logic [HW_W-1:0] rdata_q;
  logic [HW_W-1:0] rdata_d;

  // Read data only advances when a read is issued, so it holds between beats.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // Byte-lane writes and the registered read share the one address port.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem_q[addr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem_q[addr][15:8] <= wdata[15:8];
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_int_responder.sv
// RAM-backed stand-in for the SDRAM controller: accepts commands, returns
// fixed-length tagged read bursts, emulates CAS latency and refresh stalls.
module sdram_int_responder
  import sdram_int_pkg::*;
#(
  parameter int unsigned MEM_AW         = 12,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned REFRESH_PERIOD = 390,
  parameter int unsigned REFRESH_CYCLES = 6
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [15:0] dat_i,
  input  logic [1:0]  sel_i,
  input  logic        dv_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
  output logic [31:0] adr_o,
  output logic        vld_o
);

  localparam int unsigned OFF_W   = clog2(BURST_LEN);
  localparam int unsigned BEAT_W  = OFF_W + 1;
  localparam int unsigned ALIGN_W = OFF_W + 1;

  localparam logic [BEAT_W-1:0]    LAST_BEAT    = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]     LAT_INIT     = LAT_W'(RD_LATENCY - 1);
  localparam logic [REF_CYC_W-1:0] REF_CYC_INIT = REF_CYC_W'(REFRESH_CYCLES - 1);
  localparam logic [REF_CNT_W-1:0] REF_LAST     = REF_CNT_W'(REFRESH_PERIOD - 1);

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  vld_q, vld_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           base_q, base_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [REF_CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic                  pend_q, pend_d;
  logic [REF_CYC_W-1:0]  ref_cyc_q, ref_cyc_d;
  logic                  dat_ok_q, dat_ok_d;

  logic                  idle_c;
  logic                  cmd_ok_c;
  logic                  take_ref_c;
  logic                  take_wr_c;
  logic                  take_rd_c;
  logic                  issue_c;
  logic                  last_c;
  logic [MEM_AW-1:0]     ram_addr_c;
  logic [HW_W-1:0]       ram_rdata;
  logic                  unused_c;

  // Command acceptance: only from IDLE, refresh first, never while the
  // previous ack or final read beat is still on the outputs.
  assign idle_c     = (state_q == IDLE);
  assign take_ref_c = idle_c && pend_q;
  assign cmd_ok_c   = idle_c && !pend_q && acc_i && !ack_q && !vld_q;
  assign take_wr_c  = cmd_ok_c && we_i && dv_i;
  assign take_rd_c  = cmd_ok_c && !we_i;

  // A beat address goes to the RAM one cycle before the beat is presented.
  assign issue_c = ((state_q == RD_WAIT) && (lat_q == '0)) || (state_q == RD_BURST);
  assign last_c  = issue_c && (beat_q == LAST_BEAT);

  assign ram_addr_c = issue_c ? {base_q[MEM_AW:ALIGN_W], beat_q[OFF_W-1:0]}
                              : adr_i[MEM_AW:1];

  // State register.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_ref_c)     state_d = REFRESH;
        else if (take_rd_c) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == '0) state_d = last_c ? IDLE : RD_BURST;
      end
      RD_BURST: begin
        if (last_c) state_d = IDLE;
      end
      REFRESH: begin
        if (ref_cyc_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and burst datapath: ack pulse, beat issue, latency and refresh timers.
  always_comb begin
    ack_d     = 1'b0;
    vld_d     = 1'b0;
    adr_d     = adr_q;
    base_d    = base_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    ref_cyc_d = ref_cyc_q;
    dat_ok_d  = dat_ok_q;

    if (take_wr_c || take_rd_c) ack_d = 1'b1;

    if (take_rd_c) begin
      base_d = {adr_i[31:ALIGN_W], {ALIGN_W{1'b0}}};
      beat_d = '0;
      lat_d  = LAT_INIT;
    end

    if ((state_q == RD_WAIT) && (lat_q != '0)) lat_d = lat_q - LAT_W'(1);

    if (issue_c) begin
      vld_d    = 1'b1;
      adr_d    = base_q | 32'({beat_q[OFF_W-1:0], 1'b0});
      beat_d   = beat_q + BEAT_W'(1);
      dat_ok_d = 1'b1;
    end

    if (take_ref_c) begin
      ref_cyc_d = REF_CYC_INIT;
    end else if ((state_q == REFRESH) && (ref_cyc_q != '0)) begin
      ref_cyc_d = ref_cyc_q - REF_CYC_W'(1);
    end
  end

  // Free-running refresh timer; a second expiry while pending is absorbed.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    pend_d    = pend_q;
    if (REFRESH_PERIOD != 0) begin
      ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + REF_CNT_W'(1);
      if (take_ref_c)             pend_d = 1'b0;
      if (ref_cnt_d == REF_LAST)  pend_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      ack_q     <= 1'b0;
      vld_q     <= 1'b0;
      adr_q     <= '0;
      base_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      ref_cnt_q <= '0;
      pend_q    <= 1'b0;
      ref_cyc_q <= '0;
      dat_ok_q  <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      vld_q     <= vld_d;
      adr_q     <= adr_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      ref_cnt_q <= ref_cnt_d;
      pend_q    <= pend_d;
      ref_cyc_q <= ref_cyc_d;
      dat_ok_q  <= dat_ok_d;
    end
  end

  int_mem_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (sdram_clk),
    .addr  (ram_addr_c),
    .we    (take_wr_c),
    .be    (sel_i),
    .wdata (dat_i),
    .re    (issue_c),
    .rdata (ram_rdata)
  );

  // RAM read register has no reset; mask it until a beat has been read.
  assign dat_o = ram_rdata & {HW_W{dat_ok_q}};
  assign ack_o = ack_q;
  assign vld_o = vld_q;
  assign adr_o = adr_q;

  assign unused_c = adr_i[0];

endmodule

// File: tb/tb_sdram_int_responder.sv
// Bench for sdram_int_responder: transaction-level timeline model plus
// directed scenarios and randomized command traffic.
module tb_sdram_int_responder;

  localparam int BL = 8;
  localparam int RL = 2;
  localparam int RP = 20;
  localparam int RC = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc = 1'b0;
  logic        we  = 1'b0;
  logic        dv  = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0;
  logic [1:0]  sel = '0;
  logic        ack_o;
  logic        vld_o;
  logic [15:0] dat_o;
  logic [31:0] adr_o;

  sdram_int_responder #(
    .MEM_AW         (12),
    .BURST_LEN      (BL),
    .RD_LATENCY     (RL),
    .REFRESH_PERIOD (RP),
    .REFRESH_CYCLES (RC)
  ) dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .acc_i     (acc),
    .we_i      (we),
    .adr_i     (adr),
    .dat_i     (dat),
    .sel_i     (sel),
    .dv_i      (dv),
    .ack_o     (ack_o),
    .dat_o     (dat_o),
    .adr_o     (adr_o),
    .vld_o     (vld_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic [31:0] a;
    logic [15:0] d;
    bit          dk;
  } beat_t;

  beat_t       beats[$];
  int          k;
  int          busy_until;
  bit          m_pend;
  bit          m_ack;
  bit          m_vld;
  bit          m_dk;
  logic [31:0] m_adr;
  logic [15:0] m_dat;
  logic [15:0] mmem [4096];
  logic [1:0]  mknown [4096];

  int          checks;
  int          errors;
  logic [31:0] obs_adr[$];
  logic [15:0] obs_dat[$];
  int          obs_edge[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k          = 0;
    busy_until = 0;
    m_pend     = 0;
    m_ack      = 0;
    m_vld      = 0;
    m_adr      = '0;
    m_dat      = '0;
    m_dk       = 1;
    beats.delete();
  endtask

  // Timeline model: busy windows, refresh requests at fixed multiples, beat schedule.
  task automatic model_edge();
    bit          idle;
    bit          ack_prev;
    bit          vld_prev;
    int          idx;
    logic [31:0] base;
    k++;
    ack_prev = m_ack;
    vld_prev = m_vld;
    idle     = (k > busy_until);
    m_ack    = 0;
    if (idle && m_pend) begin
      busy_until = k + RC;
      m_pend     = 0;
    end else if (idle && acc && !ack_prev && !vld_prev) begin
      if (we && dv) begin
        m_ack = 1;
        idx   = int'((adr >> 1) % 4096);
        if (sel[0]) begin mmem[idx][7:0]  = dat[7:0];  mknown[idx][0] = 1'b1; end
        if (sel[1]) begin mmem[idx][15:8] = dat[15:8]; mknown[idx][1] = 1'b1; end
      end else if (!we) begin
        m_ack = 1;
        base  = adr & ~32'(2 * BL - 1);
        for (int i = 0; i < BL; i++) begin
          idx = int'(((base + 32'(2 * i)) >> 1) % 4096);
          beats.push_back('{k + RL + i, base + 32'(2 * i), mmem[idx], (mknown[idx] == 2'b11)});
        end
        busy_until = k + RL + BL - 1;
      end
    end
    if ((k % RP) == RP - 1) m_pend = 1;
    m_vld = 0;
    if (beats.size() > 0 && beats[0].edge_n == k) begin
      m_vld = 1;
      m_adr = beats[0].a;
      m_dat = beats[0].d;
      m_dk  = beats[0].dk;
      void'(beats.pop_front());
    end
  endtask

  // One clock: advance model at the edge, compare outputs at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    if (!rst) begin
      chk("ack_o", 32'(ack_o), 32'(m_ack));
      chk("vld_o", 32'(vld_o), 32'(m_vld));
      chk("adr_o", adr_o, m_adr);
      if (m_dk) chk("dat_o", 32'(dat_o), 32'(m_dat));
      if (vld_o) begin
        obs_adr.push_back(adr_o);
        obs_dat.push_back(dat_o);
        obs_edge.push_back(k);
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_obs();
    obs_adr.delete();
    obs_dat.delete();
    obs_edge.delete();
  endtask

  task automatic cmd(input bit w, input logic [31:0] a, input logic [15:0] d,
                     input logic [1:0] s, input int dvd, output int ack_edge);
    acc = 1'b1; we = w; adr = a; dat = d; sel = s;
    dv  = w && (dvd == 0);
    ack_edge = -1;
    for (int n = 0; n < 100 && ack_edge < 0; n++) begin
      cycle();
      if (ack_o) ack_edge = k;
      else if (w && (n + 1 >= dvd)) dv = 1'b1;
    end
    acc = 1'b0; dv = 1'b0; we = 1'b0;
    checks++;
    if (ack_edge < 0) begin
      errors++;
      $display("FAIL cmd_timeout adr %h got no ack expected ack within 100 cycles", a);
    end
  endtask

  initial begin
    int e;
    int r;
    int nack;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) begin
      mknown[i] = 2'b00;
      mmem[i]   = '0;
    end
    model_reset();

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    rst = 1'b0;
    model_reset();

    // refresh pending at edge 19 wins over a read held from then on
    settle(19);
    cmd(1'b0, 32'h0000_0600, 16'h0, 2'b00, 0, e);
    chk("refresh_first_ack_edge", 32'(e), 32'd27);
    settle(12);

    // write then read same address, burst timing and tags
    cmd(1'b1, 32'h0000_0100, 16'hBEEF, 2'b11, 0, e);
    clear_obs();
    cmd(1'b0, 32'h0000_0100, 16'h0, 2'b00, 0, r);
    settle(12);
    chk("t2_beats", 32'(obs_adr.size()), 32'd8);
    if (obs_adr.size() == 8) begin
      chk("t2_first_vld_edge", 32'(obs_edge[0]), 32'(r + 2));
      chk("t2_first_dat", 32'(obs_dat[0]), 32'h0000_BEEF);
      chk("t2_first_adr", obs_adr[0], 32'h0000_0100);
      chk("t2_last_adr", obs_adr[7], 32'h0000_010E);
    end

    // byte-lane merge
    cmd(1'b1, 32'h0000_0202, 16'h1234, 2'b01, 0, e);
    cmd(1'b1, 32'h0000_0202, 16'hAB00, 2'b10, 0, e);
    clear_obs();
    cmd(1'b0, 32'h0000_0200, 16'h0, 2'b00, 0, r);
    settle(12);
    chk("t3_beats", 32'(obs_adr.size()), 32'd8);
    if (obs_adr.size() == 8) begin
      chk("t3_merge_dat", 32'(obs_dat[1]), 32'h0000_AB34);
      chk("t3_merge_adr", obs_adr[1], 32'h0000_0202);
    end

    // unaligned read start is burst-aligned
    clear_obs();
    cmd(1'b0, 32'h0000_010A, 16'h0, 2'b00, 0, r);
    settle(12);
    chk("t4_beats", 32'(obs_adr.size()), 32'd8);
    if (obs_adr.size() == 8) begin
      chk("t4_first_adr", obs_adr[0], 32'h0000_0100);
      chk("t4_last_adr", obs_adr[7], 32'h0000_010E);
      chk("t4_first_dat", 32'(obs_dat[0]), 32'h0000_BEEF);
      chk("t4_span", 32'(obs_edge[7] - obs_edge[0]), 32'd7);
    end

    // write held without data valid is not acknowledged
    cmd(1'b1, 32'h0000_0300, 16'h1111, 2'b11, 0, e);
    acc = 1'b1; we = 1'b1; adr = 32'h0000_0300; dat = 16'h5A5A; sel = 2'b11; dv = 1'b0;
    nack = 0;
    repeat (5) begin
      cycle();
      if (ack_o) nack++;
    end
    chk("t5_no_ack_without_dv", 32'(nack), 32'd0);
    cmd(1'b1, 32'h0000_0300, 16'h5A5A, 2'b11, 0, e);
    clear_obs();
    cmd(1'b0, 32'h0000_0300, 16'h0, 2'b00, 0, r);
    settle(12);
    chk("t5_beats", 32'(obs_adr.size()), 32'd8);
    if (obs_adr.size() == 8) chk("t5_dat", 32'(obs_dat[0]), 32'h0000_5A5A);

    // reset during the third beat abandons the burst
    clear_obs();
    cmd(1'b0, 32'h0000_0100, 16'h0, 2'b00, 0, r);
    for (int n = 0; n < 20 && obs_adr.size() < 3; n++) cycle();
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(vld_o), 32'd0);
    chk("t6_rst_ack", 32'(ack_o), 32'd0);
    chk("t6_rst_adr", adr_o, 32'd0);
    chk("t6_rst_dat", 32'(dat_o), 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    model_reset();
    clear_obs();
    cmd(1'b0, 32'h0000_0100, 16'h0, 2'b00, 0, r);
    settle(12);
    chk("t6_beats", 32'(obs_adr.size()), 32'd8);
    if (obs_adr.size() == 8) chk("t6_dat", 32'(obs_dat[0]), 32'h0000_BEEF);

    // fill the random working region through aliased addresses
    for (int i = 0; i < 512; i++) begin
      cmd(1'b1, ($urandom & 32'hFFFF_E000) | 32'(2 * i), 16'($urandom), 2'b11, 0, e);
    end

    // random traffic
    for (int t = 0; t < 300; t++) begin
      settle($urandom_range(0, 2));
      cmd(1'($urandom_range(0, 1)),
          ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 1023)),
          16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3), e);
    end
    settle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
